nes_frame_capture: RTL and testbench
====================================

Name: nes_frame_capture

Overview:
- Synthesizable frame grabber. Samples the NES pixel stream (pixel_color, h, v) into a small FIFO and tags each pixel with x/y coordinates and frame/line markers.
- Replaces the fixed 256x240, every-4th-clock capture loop with a parametrised in-fabric block.
- Sits between the NES core video outputs and any downstream consumer: VGA scaler, frame buffer writer or debug UART dumper.
- Supports single-shot and continuous capture, back-pressure, and overflow/sync-error reporting.

Parameters:
- H_ACTIVE, 256, samples per line
- V_ACTIVE, 240, lines per frame
- PIXEL_DIV, 4, clk cycles between consecutive samples on a line (>=1)
- PIX_W, 24, pixel_color width
- FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pixel_color  in  PIX_W  pixel from NES core
- h  in  1  line-start strobe; rising edge marks line start
- v  in  1  frame-start strobe; rising edge marks frame start
- arm  in  1  start capture (honoured in IDLE only)
- stop  in  1  abort capture, return to IDLE
- continuous  in  1  1 = rearm after each frame; 0 = single frame
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid&out_ready
- out_data  out  PIX_W  captured pixel
- out_x  out  9  pixel column
- out_y  out  9  pixel row
- out_sof  out  1  head is x=0,y=0
- out_eol  out  1  head is x=H_ACTIVE-1
- out_eof  out  1  head is last pixel of frame
- busy  out  1  state != IDLE
- overflow  out  1  sticky: a sample was dropped
- sync_err  out  1  sticky: v rise arrived before frame completed
- frame_count  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0.
- Edge detect: h_q/v_q registered each cycle. h_rise = h&~h_q; v_rise = v&~v_q.
- States:
  - IDLE: arm=1 -> WAIT_V.
  - WAIT_V: v_rise -> sample x=0,y=0 this cycle, go ACTIVE.
  - ACTIVE: div counter counts 0..PIXEL_DIV-1; sample when it wraps to 0.
    - After sample x=H_ACTIVE-1: if y=V_ACTIVE-1, frame done, else y++ and go WAIT_H.
    - h/v edges in ACTIVE are ignored.
  - WAIT_H: h_rise -> sample x=0 this cycle, go ACTIVE.
    - v_rise in WAIT_H: set sync_err, restart as y=0 sample x=0, go ACTIVE. Frame not counted.
  - Frame done: frame_count++ regardless of drops; continuous=1 -> WAIT_V, else IDLE.
  - Same-cycle v_rise while going to WAIT_V is not caught; the next v_rise starts the frame.
- stop=1 in any state -> IDLE next cycle. In-flight line discarded; FIFO contents kept and still drainable. stop has priority over arm.
- Sampling: a sample pushes {pixel_color, x, y, sof, eol, eof} in the same edge.
  - out_valid rises 1 cycle after the push into an empty FIFO.
- FIFO full test uses the pre-pop count. If full at a sample: the sample is dropped, overflow=1, and x/y still advance, even if a pop occurs that same cycle.
- overflow and sync_err clear only on rst or an accepted arm.
- Pop: out_valid&out_ready advances the head next cycle. Outputs hold stable while out_valid&~out_ready.
- x, y in 9 bits; H_ACTIVE, V_ACTIVE <= 512.
- rst mid-operation: FIFO flushed and all state cleared in the same edge.

Test Plan:
- Default params, continuous=0, arm, v pulse, then 239 h pulses spaced >=1100 clk, out_ready=1 -> 61440 pixels out.
  - x steps 0..255 per line; samples exactly 4 clk apart.
  - One sof on the first pixel, 240 eol, one eof on pixel (255,239).
  - frame_count=1; busy drops 1 clk after last sample; overflow=0.
- out_ready=0 during the first line, FIFO_DEPTH=16 -> first 16 pixels retained with x=0..15; overflow=1.
  - When drained, next head is the first sample taken after space frees, with its true x.
- v_rise after 100 lines -> sync_err=1; next output has y=0, x=0, sof=1; frame_count unchanged.
- continuous=1, 3 frames -> frame_count=3; busy stays 1; stop mid-frame 2 -> IDLE next clk, FIFO still drains.
- H_ACTIVE=8, V_ACTIVE=2, PIXEL_DIV=1 -> 16 samples on consecutive clks from v_rise/h_rise.
  - eol at x=7; eof at (7,1).
- rst asserted mid-line with a non-empty FIFO -> next cycle out_valid=0, busy=0, frame_count=0, flags 0.

Source files
------------

// File: rtl/nes_frame_capture.sv
// NES video frame grabber: samples pixel_color on a fixed divider grid after h/v strobes
// and queues each pixel with its x/y coordinates and frame/line markers.
module nes_frame_capture #(
  parameter int H_ACTIVE   = 256,
  parameter int V_ACTIVE   = 240,
  parameter int PIXEL_DIV  = 4,
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_color,
  input  logic             h,
  input  logic             v,
  input  logic             arm,
  input  logic             stop,
  input  logic             continuous,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic [8:0]       out_x,
  output logic [8:0]       out_y,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             overflow,
  output logic             sync_err,
  output logic [15:0]      frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam int EW = PIX_W + 21;
  localparam logic [8:0]    X_LAST   = 9'(H_ACTIVE - 1);
  localparam logic [8:0]    Y_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_V, S_ACTIVE, S_WAIT_H} state_t;

  state_t          state_q, state_d;
  logic            h_q, v_q;
  logic [8:0]      x_q, x_d, y_q, y_d;
  logic [DW-1:0]   div_q, div_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            sync_err_q, sync_err_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic            h_rise, v_rise;
  logic            take, push, pop, full;
  logic [8:0]      smp_x, smp_y;
  logic            smp_sof, smp_eol, smp_eof;
  logic [EW-1:0]   head;

  assign h_rise = h & ~h_q;
  assign v_rise = v & ~v_q;
  assign full   = (count_q == FULL_CNT);
  assign pop    = (count_q != '0) & out_ready;

  assign smp_sof = (smp_x == 9'd0) && (smp_y == 9'd0);
  assign smp_eol = (smp_x == X_LAST);
  assign smp_eof = smp_eol && (smp_y == Y_LAST);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    div_d         = div_q;
    overflow_d    = overflow_q;
    sync_err_d    = sync_err_q;
    frame_count_d = frame_count_q;
    take          = 1'b0;
    smp_x         = x_q;
    smp_y         = y_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_WAIT_V;
          overflow_d = 1'b0;
          sync_err_d = 1'b0;
        end
      end
      S_WAIT_V: begin
        if (v_rise) begin
          take  = 1'b1;
          smp_x = 9'd0;
          smp_y = 9'd0;
        end
      end
      S_ACTIVE: begin
        if (div_q == DIV_LAST) take = 1'b1;
        else                   div_d = div_q + DW'(1);
      end
      S_WAIT_H: begin
        // A new frame start mid-frame wins over a line start: restart at row 0.
        if (v_rise) begin
          take       = 1'b1;
          smp_x      = 9'd0;
          smp_y      = 9'd0;
          sync_err_d = 1'b1;
        end else if (h_rise) begin
          take  = 1'b1;
          smp_x = 9'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      div_d = '0;
      if (smp_eol) begin
        x_d = 9'd0;
        if (smp_eof) begin
          y_d           = 9'd0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = continuous ? S_WAIT_V : S_IDLE;
        end else begin
          y_d     = smp_y + 9'd1;
          state_d = S_WAIT_H;
        end
      end else begin
        x_d     = smp_x + 9'd1;
        y_d     = smp_y;
        state_d = S_ACTIVE;
      end
    end

    push = take & ~full;
    if (take & full) overflow_d = 1'b1;

    if (stop) begin
      state_d       = S_IDLE;
      x_d           = 9'd0;
      y_d           = 9'd0;
      div_d         = '0;
      overflow_d    = overflow_q;
      sync_err_d    = sync_err_q;
      frame_count_d = frame_count_q;
      push          = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_q           <= 1'b0;
      v_q           <= 1'b0;
      x_q           <= 9'd0;
      y_q           <= 9'd0;
      div_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      h_q           <= h;
      v_q           <= v;
      x_q           <= x_d;
      y_q           <= y_d;
      div_q         <= div_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {pixel_color, smp_x, smp_y, smp_sof, smp_eol, smp_eof};
  end

  assign out_valid   = (count_q != '0);
  assign head        = out_valid ? mem[rd_ptr_q] : '0;
  assign out_data    = head[EW-1 -: PIX_W];
  assign out_x       = head[20:12];
  assign out_y       = head[11:3];
  assign out_sof     = head[2];
  assign out_eol     = head[1];
  assign out_eof     = head[0];
  assign busy        = (state_q != S_IDLE);
  assign overflow    = overflow_q;
  assign sync_err    = sync_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_nes_frame_capture.sv
// Directed bench for nes_frame_capture on a reduced 8x3 raster with a 3-clock divider
// and a 4-deep FIFO; pixel_color is a free-running count so data reveals sample timing.
module tb_nes_frame_capture;

  localparam int H  = 8;
  localparam int V  = 3;
  localparam int DV = 3;
  localparam int PW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, h, v, arm, stop, continuous, out_ready;
  logic [PW-1:0] pixel_color;
  logic          out_valid, out_sof, out_eol, out_eof, busy, overflow, sync_err;
  logic [PW-1:0] out_data;
  logic [8:0]    out_x, out_y;
  logic [15:0]   frame_count;

  nes_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_DIV(DV), .PIX_W(PW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .pixel_color(pixel_color), .h(h), .v(v),
    .arm(arm), .stop(stop), .continuous(continuous),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .busy(busy), .overflow(overflow), .sync_err(sync_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [8:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct {
    logic       arm, stop, v, rdy;
    logic       valid, busy;
    logic [8:0] x;
    logic       sof;
  } vec_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the head about to be accepted at the coming edge, then advance one clock.
  task automatic tick();
    pix_t e;
    if (sb_en && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got x=%0d y=%0d expected none", out_x, out_y);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", 32'({out_data, out_x, out_y, out_sof, out_eol, out_eof}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    pixel_color = cyc[7:0];
  endtask

  task automatic push_pix(input logic [7:0] base, input int x, input int y);
    pix_t e;
    e.d   = base + 8'(DV * x);
    e.x   = 9'(x);
    e.y   = 9'(y);
    e.sof = (x == 0) && (y == 0);
    e.eol = (x == H - 1);
    e.eof = (x == H - 1) && (y == V - 1);
    exp_q.push_back(e);
  endtask

  // Gap, then one strobe and a whole line of samples; returns right after the x=H-1 edge.
  task automatic run_line(input bit use_v, input int y, input logic [7:0] drop, input int ready_at);
    logic [7:0] base;
    repeat (3) tick();
    base = pixel_color;
    for (int x = 0; x < H; x++)
      if (!drop[x]) push_pix(base, x, y);
    if (use_v) v = 1'b1;
    else       h = 1'b1;
    for (int i = 0; i < (H - 1) * DV + 1; i++) begin
      if (i == ready_at) out_ready = 1'b1;
      tick();
      v = 1'b0;
      h = 1'b0;
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fc"}, 32'(frame_count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_serr"}, 32'(sync_err), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    //          arm  stop v    rdy  | valid busy x  sof
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};

    rst = 1'b1; h = 1'b0; v = 1'b0; arm = 1'b0; stop = 1'b0;
    continuous = 1'b0; out_ready = 1'b0; pixel_color = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Cycle table: arm, frame start, divider spacing, valid latency, pop, stop priority.
    for (int i = 0; i < 12; i++) begin
      arm = tbl[i].arm; stop = tbl[i].stop; v = tbl[i].v; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), 32'({out_valid, busy, out_x, out_sof}),
          32'({tbl[i].valid, tbl[i].busy, tbl[i].x, tbl[i].sof}));
    end
    arm = 1'b0; stop = 1'b0; v = 1'b0; out_ready = 1'b0;

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;

    // Single full frame with a free-flowing consumer.
    out_ready = 1'b1;
    arm_pulse();
    chk("b_busy_armed", 32'(busy), 32'd1);
    run_line(1'b1, 0, 8'h00, -1);
    run_line(1'b0, 1, 8'h00, -1);
    chk("b_busy_waith", 32'(busy), 32'd1);
    run_line(1'b0, 2, 8'h00, -1);
    chk("b_busy_done", 32'(busy), 32'd0);
    chk("b_fc", 32'(frame_count), 32'd1);
    chk("b_ovf", 32'(overflow), 32'd0);
    drain(6);

    // Stalled consumer on line 0: x=4,5 dropped, x=6 lands after space frees.
    out_ready = 1'b0;
    arm_pulse();
    run_line(1'b1, 0, 8'h30, 16);
    chk("c_ovf", 32'(overflow), 32'd1);
    run_line(1'b0, 1, 8'h00, -1);
    run_line(1'b0, 2, 8'h00, -1);
    chk("c_fc", 32'(frame_count), 32'd2);
    chk("c_ovf_sticky", 32'(overflow), 32'd1);
    drain(6);

    // Frame restart from WAIT_H on an early v edge.
    arm_pulse();
    chk("d_ovf_cleared", 32'(overflow), 32'd0);
    run_line(1'b1, 0, 8'h00, -1);
    run_line(1'b1, 0, 8'h00, -1);
    chk("d_serr", 32'(sync_err), 32'd1);
    chk("d_fc_same", 32'(frame_count), 32'd2);
    run_line(1'b0, 1, 8'h00, -1);
    run_line(1'b0, 2, 8'h00, -1);
    chk("d_fc", 32'(frame_count), 32'd3);
    chk("d_serr_sticky", 32'(sync_err), 32'd1);
    drain(6);

    // Continuous capture of three frames, then stop part way into the next.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("e_fc_reset", 32'(frame_count), 32'd0);
    continuous = 1'b1;
    arm_pulse();
    for (int f = 0; f < 3; f++) begin
      run_line(1'b1, 0, 8'h00, -1);
      run_line(1'b0, 1, 8'h00, -1);
      run_line(1'b0, 2, 8'h00, -1);
      chk($sformatf("e_busy%0d", f), 32'(busy), 32'd1);
      chk($sformatf("e_fc%0d", f), 32'(frame_count), 32'(f + 1));
    end
    drain(4);
    out_ready = 1'b0;
    repeat (3) tick();
    begin
      logic [7:0] base;
      base = pixel_color;
      for (int x = 0; x < 3; x++) push_pix(base, x, 0);
    end
    v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      v = 1'b0;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("e_stop_busy", 32'(busy), 32'd0);
    chk("e_stop_valid", 32'(out_valid), 32'd1);
    chk("e_stop_fc", 32'(frame_count), 32'd3);
    drain(6);

    // Reset mid-line with a full FIFO and overflow set.
    continuous = 1'b0;
    out_ready = 1'b0;
    arm_pulse();
    repeat (3) tick();
    v = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      v = 1'b0;
    end
    chk("f_ovf_pre", 32'(overflow), 32'd1);
    chk("f_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset_state("f_rst");
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
